// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with one-cycle special cases.
// Optional build macro EXU_DIV_EARLY_OUT_EN: skip the iteration loop when |dividend| < |divisor|.
module exu_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    input  logic            rem,
    input  logic            unsign,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic [31:0]     instr_tag,
    output logic            busy,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd_addr,
    output logic [31:0]     wb_tag,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state, w_next;
    logic [5:0]      r_cnt;
    logic [XLEN:0]   r_rem_acc;
    logic [XLEN-1:0] r_quo, r_divisor;
    logic            r_q_neg, r_r_neg, r_rem_sel;
    logic [4:0]      r_rd;
    logic [31:0]     r_tag;
    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_data;
    logic [4:0]      r_wb_rd;
    logic [31:0]     r_wb_tag;

    logic            w_accept, w_s1, w_s2, w_div0, w_ovf, w_special, w_early, w_ge;
    logic [XLEN-1:0] w_mag1, w_mag2, w_spec_res, w_quo_fix, w_rem_mag, w_rem_fix;
    logic [XLEN:0]   w_shift, w_sub;

    // Handshake: div_valid is a one-cycle issue strobe, honoured only while busy is low
    // and flush is low; results leave as a one-cycle wb_valid pulse with no backpressure.
    assign w_accept   = (r_state == S_IDLE) & div_valid & ~flush;
    assign w_s1       = ~unsign & rs1_data[XLEN-1];
    assign w_s2       = ~unsign & rs2_data[XLEN-1];
    assign w_mag1     = w_s1 ? (~rs1_data + XLEN'(1)) : rs1_data;
    assign w_mag2     = w_s2 ? (~rs2_data + XLEN'(1)) : rs2_data;
    assign w_div0     = (rs2_data == '0);
    assign w_ovf      = ~unsign & (rs1_data == MIN_NEG) & (&rs2_data);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (rem ? rs1_data : '1) : (rem ? '0 : MIN_NEG);
`ifdef EXU_DIV_EARLY_OUT_EN
    assign w_early    = (w_mag1 < w_mag2);
`else
    assign w_early    = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_shift    = {r_rem_acc[XLEN-1:0], r_quo[XLEN-1]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_sub      = w_shift - {1'b0, r_divisor};

    assign w_rem_mag  = XLEN'(r_rem_acc);
    assign w_quo_fix  = r_q_neg ? (~r_quo + XLEN'(1)) : r_quo;
    assign w_rem_fix  = r_r_neg ? (~w_rem_mag + XLEN'(1)) : w_rem_mag;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special)    w_next = S_DONE;
                    else if (w_early) w_next = S_FIX;
                    else              w_next = S_CALC;
                end
            end
            S_CALC:  if (r_cnt == 6'd1) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem_acc  <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_rem_sel  <= 1'b0;
            r_rd       <= '0;
            r_tag      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
            r_wb_tag   <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem_sel <= rem;
                        r_rd      <= rd_addr;
                        r_tag     <= instr_tag;
                        r_divisor <= w_mag2;
                        r_q_neg   <= w_s1 ^ w_s2;
                        r_r_neg   <= w_s1;
                        r_cnt     <= 6'(XLEN);
                        if (w_special) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_spec_res;
                            r_wb_rd    <= rd_addr;
                            r_wb_tag   <= instr_tag;
                        end else if (w_early) begin
                            r_quo     <= '0;
                            r_rem_acc <= {1'b0, w_mag1};
                        end else begin
                            r_quo     <= w_mag1;
                            r_rem_acc <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem_acc <= w_ge ? w_sub : w_shift;
                    r_quo     <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt     <= r_cnt - 6'd1;
                end
                S_FIX: begin
                    if (!flush) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= r_rem_sel ? w_rem_fix : w_quo_fix;
                        r_wb_rd    <= r_rd;
                        r_wb_tag   <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_rd_addr = r_wb_rd;
    assign wb_tag     = r_wb_tag;
    assign dbg_state  = r_state;

    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (rst) !(div_valid && busy))
        else $error("exu_div: div_valid asserted while busy");

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: directed test-plan cases, flush/reset cases and random operands
// checked every cycle against an arithmetic reference model.
module tb_exu_div;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, rem, unsign;
  logic [31:0] rs1_data, rs2_data, instr_tag;
  logic [4:0]  rd_addr;
  logic        busy, wb_valid;
  logic [31:0] wb_data, wb_tag;
  logic [4:0]  wb_rd_addr;
  logic [1:0]  dbg_state;

  exu_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .rem(rem), .unsign(unsign),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .instr_tag(instr_tag),
    .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_tag(wb_tag), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [31:0] exp_tag_q[$];
  bit          pend = 0;
  bit          chk_en = 0;
  int          due = 0;
  int          last_t = 0;
  logic [31:0] hold_data = '0;
  logic [31:0] hold_tag = '0;
  logic [4:0]  hold_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_div(input bit r, input bit u, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (u) return r ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    return r ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int lat_of(input bit u, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (b == 32'd0 || (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    ma = (!u && a[31]) ? -a : a;
    mb = (!u && b[31]) ? -b : b;
`ifdef EXU_DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return 34;
`endif
    return 34;
  endfunction

  // ---------------- compare process: every cycle, just after the active edge ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        bit exp_b, exp_v;
        exp_b = pend;
        exp_v = pend && (cyc == due);
        if (exp_v) begin
          hold_data = exp_q.pop_front();
          hold_rd   = exp_rd_q.pop_front();
          hold_tag  = exp_tag_q.pop_front();
          pend      = 0;
        end
        check("busy", {31'd0, busy}, {31'd0, exp_b});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
        check("wb_data", wb_data, hold_data);
        check("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, hold_rd});
        check("wb_tag", wb_tag, hold_tag);
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic issue(input bit r, input bit u, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    rem       = r;
    unsign    = u;
    rs1_data  = a;
    rs2_data  = b;
    rd_addr   = 5'($urandom_range(1, 31));
    instr_tag = $urandom;
    div_valid = 1'b1;
    exp_q.push_back(exp);
    exp_rd_q.push_back(rd_addr);
    exp_tag_q.push_back(instr_tag);
    last_t = cyc + 1;
    due    = last_t + lat_of(u, a, b) - 1;
    pend   = 1;
    @(negedge clk);
    div_valid = 1'b0;
  endtask

  task automatic kill_pending();
    pend = 0;
    due  = cyc;
    exp_q.delete();
    exp_rd_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (!pend && cyc > due) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL timeout: operation still pending at cycle %0d (state %0d) required done by %0d",
             cyc, dbg_state, due);
    kill_pending();
  endtask

  task automatic run(input bit r, input bit u, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    issue(r, u, a, b, ref_div(r, u, a, b));
  endtask

  task automatic directed(input bit r, input bit u, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit);
    wait_idle();
    check("model_pin", ref_div(r, u, a, b), lit);
    issue(r, u, a, b, lit);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'($urandom_range(0, 2000)) - 32'd1000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; rem = 1'b0; unsign = 1'b0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0; instr_tag = '0;
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    directed(0, 1, 32'd100, 32'd7, 32'd14);
    directed(1, 1, 32'd100, 32'd7, 32'd2);
    directed(0, 0, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
    directed(1, 0, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
    directed(1, 0, 32'd20, 32'hFFFF_FFFD, 32'd2);
    directed(0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF);
    directed(1, 0, 32'd5, 32'd0, 32'd5);
    directed(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    directed(0, 1, 32'd3, 32'd10, 32'd0);
    directed(1, 1, 32'd3, 32'd10, 32'd3);
    directed(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush during CALC, then a new DIVU issued in the very next cycle.
    run(0, 0, 32'd1000, 32'd7);
    while (cyc < last_t + 9) @(negedge clk);
    flush = 1'b1;
    kill_pending();
    @(negedge clk);
    flush = 1'b0;
    issue(0, 1, 32'd9, 32'd3, 32'd3);

    // Reset mid-operation drops the result and clears the outputs.
    run(1, 0, 32'hFFFF_CFC7, 32'd77);
    while (cyc < last_t + 19) @(negedge clk);
    rst = 1'b1;
    kill_pending();
    hold_data = '0;
    hold_rd   = '0;
    hold_tag  = '0;
    @(negedge clk);
    rst = 1'b0;

    // Issue together with flush is never accepted.
    div_valid = 1'b1;
    flush     = 1'b1;
    rs1_data  = 32'd50;
    rs2_data  = 32'd5;
    @(negedge clk);
    div_valid = 1'b0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
